icache_direct: RTL
==================

Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage and backing memory.
- Fetch side uses the fields of Bundle::ICacheOut (request) and Bundle::ICacheIn (response). Memory side uses Bundle::MemoryIn and Bundle::MemoryOut.
- On a miss, refills one line with sequential word reads, then returns the requested word.

Parameters:
- LINES, 16, number of lines (power of 2, at least 2)
- WORDS, 4, 32-bit words per line (power of 2, at least 2; 4 gives a 128-bit line)

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  fetch request valid (ICacheOut.request_valid)
- req_addr  in  32  fetch byte address (ICacheOut.request.address); bits [1:0] ignored
- req_ready  out  1  cache can accept a request this cycle
- resp_ready  in  1  fetch accepts response (ICacheOut.response_ready)
- resp_valid  out  1  response valid (ICacheIn.response_valid)
- resp_data  out  32  requested word (ICacheIn.response.data)
- resp_data_block  out  129  [32*WORDS-1:0] = full line, remaining upper bits 0 (ICacheIn.response.data_block)
- invalidate  in  1  clear all valid bits (ICacheIn.invalidate)
- mem_req_valid  out  1  memory request valid (MemoryIn.req_valid)
- mem_req_addr  out  32  word address of refill read
- mem_req_data  out  32  always 0
- mem_req_fcn  out  2  always M_XRD (0)
- mem_req_typ  out  3  always MT_W (4)
- mem_req_ready  in  1  memory accepts request (MemoryOut.req_ready)
- mem_res_valid  in  1  memory read data valid (MemoryOut.res_valid)
- mem_res_data  in  32  memory read data

Behaviour:
- Address split: offset = addr[log2(WORDS)+1:2], index = next log2(LINES) bits, tag = remaining upper bits.
- Storage: tag and valid in flops; data in a flop array or sync RAM.
- Reset:
  - state IDLE; all valid bits 0
  - resp_valid = 0, mem_req_valid = 0, req_ready = 1 after reset deasserts
  - resp_data, resp_data_block and mem_req_addr = 0
- FSM states: IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, RESPOND.
- IDLE:
  - req_ready = 1
  - req_valid accepted: latch address, go to LOOKUP
  - req_ready = 0 in every other state
- LOOKUP (1 cycle):
  - hit (valid & tag match): load response registers, go to RESPOND
  - miss: word counter = 0, go to REFILL_REQ
- Hit latency: resp_valid asserts 2 cycles after the accept edge.
- REFILL_REQ:
  - mem_req_valid = 1, mem_req_addr = line base + 4*counter (line base = addr with the low log2(WORDS)+2 bits cleared)
  - held stable until mem_req_ready; then go to REFILL_WAIT
- REFILL_WAIT:
  - mem_req_valid = 0; exactly one memory request outstanding
  - on mem_res_valid: write word[counter]
  - if counter == WORDS-1: write tag, set valid (unless invalidated, see below), load response from the refilled data (requested word bypassed correctly even when it is the last word), go to RESPOND
  - else: counter+1, go to REFILL_REQ
  - mem_res_valid ignored in any other state
- RESPOND:
  - resp_valid = 1; resp_data and resp_data_block held stable until resp_ready
  - on resp_valid & resp_ready: go to IDLE; next request accepted the following cycle (no same-cycle accept)
- invalidate:
  - clears all valid bits on that edge
  - in LOOKUP in the same cycle: treated as a miss
  - during refill (any time from the miss to the final write): the line is filled and the response delivered, but valid is not set
  - in RESPOND: the pending response is still delivered
- Conflict: a miss overwrites the line at its index unconditionally.
- reset mid-refill or mid-response: return to IDLE and drop the transaction; late mem_res_valid is ignored.

Test Plan:
- Cold miss: reset, req 0x0000_0104 -> 4 mem reads at 0x100, 0x104, 0x108, 0x10C (typ 4, fcn 0); respond with 0xA0..0xA3 -> resp_data = 0xA1, resp_data_block[127:0] = {A3, A2, A1, A0}.
- Hit: then req 0x0000_010C -> resp_valid 2 cycles after accept, data 0xA3, no mem_req_valid.
- Conflict and invalidate: req 0x0000_0504 (same index, new tag) -> refill from 0x500. Then invalidate = 1 for one cycle, then req 0x0000_0504 -> misses again.
- Backpressure:
  - mem_req_ready held 0 for 5 cycles -> mem_req_valid and addr stable throughout
  - resp_ready held 0 for 3 cycles -> resp_valid and data stable, req_ready = 0
- Invalidate mid-refill: assert invalidate after the 2nd refill word -> response delivered correctly; a repeat request to the same address misses.
- Reset mid-refill: assert reset in REFILL_WAIT, then a stray mem_res_valid -> ignored. The same address then misses and refills cleanly from word 0.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache. Misses refill a whole line
// with sequential single-word reads before the requested word is returned.
module icache_direct #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    input  logic [31:0]  req_addr,
    output logic         req_ready,
    input  logic         resp_ready,
    output logic         resp_valid,
    output logic [31:0]  resp_data,
    output logic [128:0] resp_data_block,
    input  logic         invalidate,
    output logic         mem_req_valid,
    output logic [31:0]  mem_req_addr,
    output logic [31:0]  mem_req_data,
    output logic [1:0]   mem_req_fcn,
    output logic [2:0]   mem_req_typ,
    input  logic         mem_req_ready,
    input  logic         mem_res_valid,
    input  logic [31:0]  mem_res_data
);

    localparam int unsigned OFF_W   = $clog2(WORDS);
    localparam int unsigned IDX_W   = $clog2(LINES);
    localparam int unsigned LSB_IDX = OFF_W + 2;
    localparam int unsigned TAG_LSB = OFF_W + IDX_W + 2;
    localparam int unsigned TAG_W   = 32 - TAG_LSB;
    localparam int unsigned LINE_W  = 32 * WORDS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL_REQ,
        S_REFILL_WAIT,
        S_RESPOND
    } state_e;

    state_e              state_q, state_d;
    logic [31:2]         waddr_q, waddr_d;
    logic [OFF_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         maddr_q, maddr_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [LINE_W-1:0]   rblock_q, rblock_d;
    logic                inval_pend_q, inval_pend_d;

    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [31:0]         data_q [LINES][WORDS];

    logic [IDX_W-1:0]    idx_c;
    logic [OFF_W-1:0]    off_c;
    logic [TAG_W-1:0]    tag_c;
    logic                hit_c;
    logic                last_c;
    logic                fill_we_c;
    logic                fill_done_c;
    logic [31:0]         words_c [WORDS];
    logic [LINE_W-1:0]   line_c;
    logic                unused_addr_c;

    assign idx_c       = waddr_q[TAG_LSB-1:LSB_IDX];
    assign off_c       = waddr_q[LSB_IDX-1:2];
    assign tag_c       = waddr_q[31:TAG_LSB];
    assign hit_c       = valid_q[idx_c] && (tag_q[idx_c] == tag_c) && !invalidate;
    assign last_c      = (cnt_q == OFF_W'(WORDS - 1));
    assign fill_we_c   = (state_q == S_REFILL_WAIT) && mem_res_valid;
    assign fill_done_c = fill_we_c && last_c;
    assign unused_addr_c = ^req_addr[1:0];

    assign req_ready       = (state_q == S_IDLE);
    assign resp_valid      = (state_q == S_RESPOND);
    assign resp_data       = rdata_q;
    assign resp_data_block = 129'(rblock_q);
    assign mem_req_valid   = (state_q == S_REFILL_REQ);
    assign mem_req_addr    = maddr_q;
    assign mem_req_data    = 32'd0;
    assign mem_req_fcn     = 2'd0;
    assign mem_req_typ     = 3'd4;

    // Current line view, with the incoming refill word bypassed over storage
    always_comb begin
        words_c = '{default: '0};
        line_c  = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            words_c[OFF_W'(w)] = (fill_we_c && (cnt_q == OFF_W'(w))) ? mem_res_data
                                                                     : data_q[idx_c][OFF_W'(w)];
            line_c[w*32 +: 32] = words_c[OFF_W'(w)];
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d      = state_q;
        waddr_d      = waddr_q;
        cnt_d        = cnt_q;
        maddr_d      = maddr_q;
        rdata_d      = rdata_q;
        rblock_d     = rblock_q;
        inval_pend_d = inval_pend_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    waddr_d = req_addr[31:2];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit_c) begin
                    rdata_d  = words_c[off_c];
                    rblock_d = line_c;
                    state_d  = S_RESPOND;
                end else begin
                    cnt_d        = '0;
                    maddr_d      = {waddr_q[31:LSB_IDX], LSB_IDX'(0)};
                    inval_pend_d = invalidate;
                    state_d      = S_REFILL_REQ;
                end
            end
            S_REFILL_REQ: begin
                if (invalidate) inval_pend_d = 1'b1;
                if (mem_req_ready) state_d = S_REFILL_WAIT;
            end
            S_REFILL_WAIT: begin
                if (invalidate) inval_pend_d = 1'b1;
                if (mem_res_valid) begin
                    if (last_c) begin
                        rdata_d  = words_c[off_c];
                        rblock_d = line_c;
                        state_d  = S_RESPOND;
                    end else begin
                        cnt_d   = OFF_W'(cnt_q + 1'b1);
                        maddr_d = maddr_q + 32'd4;
                        state_d = S_REFILL_REQ;
                    end
                end
            end
            S_RESPOND: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, response registers and valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            waddr_q      <= '0;
            cnt_q        <= '0;
            maddr_q      <= '0;
            rdata_q      <= '0;
            rblock_q     <= '0;
            inval_pend_q <= 1'b0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            cnt_q        <= cnt_d;
            maddr_q      <= maddr_d;
            rdata_q      <= rdata_d;
            rblock_q     <= rblock_d;
            inval_pend_q <= inval_pend_d;
            if (invalidate) begin
                valid_q <= '0;
            end else if (fill_done_c && !inval_pend_q) begin
                valid_q[idx_c] <= 1'b1;
            end
        end
    end

    // Tag and data storage; contents are qualified by valid_q
    always_ff @(posedge clk) begin
        if (fill_we_c) begin
            data_q[idx_c][cnt_q] <= mem_res_data;
        end
        if (fill_done_c) begin
            tag_q[idx_c] <= tag_c;
        end
    end

endmodule
